tmds_channel_encoder: RTL

TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

---
 rtl/tmds_channel_encoder.sv | 99 +++++++++
 1 files changed

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder: stage 1 builds the transition-minimised word q_m,
// stage 2 applies DC balancing against a running disparity or emits control tokens.
module tmds_channel_encoder (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [7:0] prefix_xor(input logic [7:0] v);
    logic [7:0] p;
    p[0] = v[0];
    for (int i = 1; i < 8; i++) begin
      p[i] = p[i-1] ^ v[i];
    end
    return p;
  endfunction

  logic [8:0]        q_m_d, q_m_q;
  logic              ve_d, ve_q;
  logic [1:0]        ctrl_d, ctrl_q;
  logic [9:0]        tmds_d, tmds_q;
  logic signed [4:0] cnt_d, cnt_q;

  logic [3:0]        n1_s, n1q_s;
  logic              use_xnor_s;
  logic signed [5:0] diff_s, cnt_ext_s, sum_s;

  // An XNOR chain equals the XOR prefix with every odd-position bit inverted.
  always_comb begin
    n1_s       = popcount8(data_in);
    use_xnor_s = (n1_s > 4'd4) || ((n1_s == 4'd4) && !data_in[0]);
    q_m_d      = {~use_xnor_s, prefix_xor(data_in) ^ (use_xnor_s ? 8'hAA : 8'h00)};
    ve_d       = ve_in;
    ctrl_d     = control_in;
  end

  // diff_s is N1q - N0q; sums are done one bit wider, the result always fits cnt.
  always_comb begin
    n1q_s     = popcount8(q_m_q[7:0]);
    diff_s    = $signed({1'b0, n1q_s, 1'b0}) - 6'sd8;
    cnt_ext_s = {cnt_q[4], cnt_q};
    sum_s     = 6'sd0;
    tmds_d    = 10'h000;
    cnt_d     = 5'sd0;
    if (!ve_q) begin
      case (ctrl_q)
        2'b00:   tmds_d = 10'h354;
        2'b01:   tmds_d = 10'h0AB;
        2'b10:   tmds_d = 10'h154;
        2'b11:   tmds_d = 10'h2AB;
        default: tmds_d = 10'h354;
      endcase
      cnt_d = 5'sd0;
    end else if ((cnt_q == 5'sd0) || (n1q_s == 4'd4)) begin
      tmds_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      sum_s  = q_m_q[8] ? (cnt_ext_s + diff_s) : (cnt_ext_s - diff_s);
      cnt_d  = sum_s[4:0];
    end else if ((!cnt_q[4] && (n1q_s > 4'd4)) || (cnt_q[4] && (n1q_s < 4'd4))) begin
      tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      sum_s  = cnt_ext_s + $signed({4'b0000, q_m_q[8], 1'b0}) - diff_s;
      cnt_d  = sum_s[4:0];
    end else begin
      tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      sum_s  = cnt_ext_s - $signed({4'b0000, ~q_m_q[8], 1'b0}) + diff_s;
      cnt_d  = sum_s[4:0];
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      q_m_q  <= 9'd0;
      ve_q   <= 1'b0;
      ctrl_q <= 2'b00;
      tmds_q <= 10'h000;
      cnt_q  <= 5'sd0;
    end else begin
      q_m_q  <= q_m_d;
      ve_q   <= ve_d;
      ctrl_q <= ctrl_d;
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds_out = tmds_q;

endmodule
